// File: rtl/pwm_pkg.sv
// ====================================================================
// pwm_pkg -- shared PWM types and constants (generator and capture)
// Macro: PWM_CAPTURE_DEGLITCH_EN deepens the capture input pipeline
// Rev 1.0
// ====================================================================
`default_nettype none

package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT = 4;

  // Cycles after reset release before the conditioned level reflects real samples
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int COND_PRIME_DEPTH = 5;
`else
  localparam int COND_PRIME_DEPTH = 2;
`endif

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_in_cond.sv
// ====================================================================
// pwm_in_cond -- synchronizer, optional majority deglitch, edge detect
// Macro: PWM_CAPTURE_DEGLITCH_EN inserts a 3-sample majority filter
// Rev 1.0
// ====================================================================
`default_nettype none

module pwm_in_cond
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic primed_o
);

  logic                        s1_q;
  logic                        s2_q;
  logic                        s3_q;
  logic                        lvl;
  logic [COND_PRIME_DEPTH-1:0] prime_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pwm_i;
      s2_q <= s1_q;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic m0_q;
  logic m1_q;
  logic filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q   <= 1'b0;
      m1_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      m0_q   <= s2_q;
      m1_q   <= m0_q;
      filt_q <= (s2_q & m0_q) | (s2_q & m1_q) | (m0_q & m1_q);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  // prime_q fills with ones so SEEK ignores reset-value zeros still in the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_q    <= 1'b0;
      prime_q <= '0;
    end else begin
      s3_q    <= lvl;
      prime_q <= {prime_q[COND_PRIME_DEPTH-2:0], 1'b1};
    end
  end

  assign level_o  = lvl;
  assign rise_o   = lvl & ~s3_q;
  assign fall_o   = ~lvl & s3_q;
  assign primed_o = prime_q[COND_PRIME_DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ====================================================================
// pwm_capture -- per-period high time / period measurement of a PWM input
// Macro: PWM_CAPTURE_DEGLITCH_EN rejects 1-cycle input pulses
// Rev 1.0
// ====================================================================
`default_nettype none

module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] wave_length,
  output logic             valid,
  output logic             overflow,
  output logic             stuck,
  output logic             level
);

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   IDLE_LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   IDLE_SAT  = {1'b1, {WIDTH{1'b0}}};

  logic rise;
  logic fall;
  logic primed;
  logic edge_seen;
  logic timeout;

  cap_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   idle_q, idle_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             oflow_q, oflow_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  pwm_in_cond u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_i    (pwm_in),
    .level_o  (level),
    .rise_o   (rise),
    .fall_o   (fall),
    .primed_o (primed)
  );

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    h_d       = h_q;
    ovf_d     = ovf_q;
    high_d    = high_q;
    wave_d    = wave_q;
    oflow_d   = oflow_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    edge_seen = rise | fall;
    // An edge in the threshold cycle keeps the idle count from ever firing
    timeout   = !edge_seen && (idle_q == IDLE_LAST);
    idle_d    = edge_seen ? '0 : ((idle_q == IDLE_SAT) ? idle_q : idle_q + 1'b1);

    if (edge_seen) begin
      stuck_d = 1'b0;
    end

    if (timeout) begin
      stuck_d = 1'b1;
      state_d = SEEK;
      p_d     = '0;
      h_d     = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        SEEK: begin
          if (primed && !level) begin
            state_d = ARM;
          end
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            p_d     = CNT_ONE;
            h_d     = CNT_ONE;
            ovf_d   = 1'b0;
          end
        end
        HIGH: begin
          if (p_q == CNT_MAX) ovf_d = 1'b1;
          else                p_d   = p_q + 1'b1;
          if (fall)                state_d = LOW;
          else if (h_q == CNT_MAX) ovf_d   = 1'b1;
          else                     h_d     = h_q + 1'b1;
        end
        LOW: begin
          if (rise) begin
            wave_d  = p_q;
            high_d  = h_q;
            oflow_d = ovf_q;
            valid_d = 1'b1;
            p_d     = CNT_ONE;
            h_d     = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = HIGH;
          end else if (p_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEEK;
      p_q     <= '0;
      h_q     <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= '0;
      high_q  <= '0;
      wave_q  <= '0;
      oflow_q <= 1'b0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
      high_q  <= high_d;
      wave_q  <= wave_d;
      oflow_q <= oflow_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  assign high_time   = high_q;
  assign wave_length = wave_q;
  assign overflow    = oflow_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;

endmodule

`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

- Measures an incoming PWM waveform: per-period high time and period length, in `clk` cycles.
- Counterpart of the `pwm` generator used by the LED display blocks. It closes the loop in self-test benches and serves PWM-driven inputs on the board.
- Reports a result once per complete period with a one-cycle `valid` strobe. Flags saturation and loss of signal.

## Interface
- `WIDTH`, default 4: counter and result width; the maximum measurable count is 2^WIDTH-1.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pwm_in`  in  1  PWM input, asynchronous to `clk`.
- `high_time`  out  WIDTH  high cycles of the last complete period.
- `wave_length`  out  WIDTH  total cycles of the last complete period, rise to rise.
- `valid`  out  1  one-cycle strobe; results updated this cycle.
- `overflow`  out  1  qualifies the current results: a counter saturated during that period.
- `stuck`  out  1  no edge for 2^WIDTH cycles; measurement abandoned.
- `level`  out  1  current conditioned input level; distinguishes 0% from 100% duty while `stuck`.

## Operation
- **Input conditioning:** two-flop synchronizer s1→s2, then history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3; `level` = s2.
- **FSM states:** SEEK, ARM, HIGH, LOW. Reset state is SEEK.
  - SEEK: when s2 = 0, go to ARM. This rejects a false rise when the input is already high at reset release.
  - ARM: on rise, go to HIGH; set period count p = 1 and high count h = 1.
  - HIGH: p++ and h++ every cycle. On fall, go to LOW; h freezes and p++.
  - LOW: p++. On rise:
    - `wave_length` ← p, `high_time` ← h, `overflow` ← ovf, `valid` = 1.
    - Then p = 1, h = 1, ovf = 0, go to HIGH.
- **Arithmetic:**
  - p and h saturate at 2^WIDTH-1.
  - An increment attempted at saturation sets internal ovf. ovf is sticky until the period completes.
- **Loss of signal:**
  - An idle counter of WIDTH+1 bits resets on every rise or fall and counts otherwise.
  - When it reaches 2^WIDTH, in any state: set `stuck`, discard p, h and ovf, and go to SEEK.
  - `stuck` clears on the next edge.
- **Held values:** `high_time`, `wave_length` and `overflow` hold their last values between strobes, including while `stuck`.
- **Reset:**
  - All outputs are 0: `high_time`, `wave_length`, `valid`, `overflow`, `stuck`, `level`.
  - Sync flops and counters are 0. State is SEEK.
  - Asserting reset mid-period discards the partial measurement. The first strobe after reset needs ARM followed by one full period.
- **Simultaneous events:** an edge in the same cycle as the idle threshold wins; no stuck.

## Timing
- All outputs are registered.
- From a `pwm_in` transition ahead of edge k, the effect appears after edge k+2: 3-edge latency.
- `valid` is high for exactly one cycle per completed period and never in back-to-back cycles.
- Minimum detectable pulse is 1 cycle: high_time = 1, wave_length ≥ 2.
- The first `valid` comes at the second rise after ARM is entered.

## Configuration
- `PWM_CAPTURE_DEGLITCH_EN` defined:
  - A 3-sample majority filter sits between s2 and s3. s2 is replaced by the filter output for `level` and for edge detection.
  - Pulses of 1 cycle are rejected.
  - Latency increases to 5 edges.
  - Minimum measured high or low time is 2.
- Undefined: no filter; behaviour as described above.

## Structure
- Shared package `pwm_pkg` holds:
  - the capture FSM state enum (SEEK, ARM, HIGH, LOW);
  - the default width constant `PWM_WIDTH_DEFAULT = 4`, shared with the generator side.
- Sub-module `pwm_in_cond` holds the synchronizer, the optional deglitch filter and the edge detect.
  - Outputs: `level`, `rise`, `fall`.
- The top level holds the FSM, counters and output registers.

## Test plan
All scenarios use WIDTH = 4.
- Steady input, period 10, high 3:
  - After the second rise, `valid` pulses every 10 cycles.
  - Results: high_time = 3, wave_length = 10, overflow = 0.
- Input high across reset release, then low 5 / high 4 / low 6 repeating:
  - No `valid` from the truncated first high.
  - First result: high_time = 4, wave_length = 10.
- Period 20, high 5: wave_length = 15, high_time = 5, overflow = 1 on each strobe.
- After valid results, hold input low:
  - `stuck` = 1 on the 16th edgeless cycle; `valid` stays 0; `level` = 0; results held.
  - The next rise clears `stuck`. The next valid result follows after one full period.
- `rst_n` low mid-HIGH:
  - All outputs 0 immediately, asynchronously.
  - After release, no `valid` until ARM plus one full period.
- Period 10 with an extra 1-cycle high glitch mid-LOW:
  - Macro undefined: a strobe with high_time = 1.
  - Macro defined: glitch ignored; results stay 3 / 10.
